// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the 4x4 elevator keypad scan path.
//   NUM_COLS / NUM_ROWS : keypad geometry (fixed at 4x4)
//   key_code_t          : {col, row} key code handed to the request logic
//   scan_state_t        : column-slot phase (SETTLE, SAMPLE)
//   lowest_set()        : index of the lowest set bit of a row vector
package keypad_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_ROWS = 4;

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } key_code_t;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        SAMPLE = 1'b1
    } scan_state_t;

    function automatic logic [1:0] lowest_set(input logic [NUM_ROWS-1:0] v);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            if (v[i] && !found) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_sequencer.sv
// keypad_col_sequencer: drives the keypad columns one-hot and times each
// column slot as SETTLE_CYCLES of line settling followed by SAMPLE_CYCLES
// with the edge-detect enable high.
//   clk, rst   : clock, asynchronous active-high reset
//   col        : one-hot column drive (registered)
//   col_idx    : binary index of the driven column
//   en         : edge-detect enable, high only in SAMPLE (registered)
//   slot_last  : high on the final SAMPLE cycle of the current slot
module keypad_col_sequencer
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SAMPLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_COLS-1:0] col,
    output logic [1:0]          col_idx,
    output logic                en,
    output logic                slot_last
);

    localparam int unsigned MAXC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);

    scan_state_t   state;
    logic [CW-1:0] cnt;

    assign slot_last = (state == SAMPLE) && (cnt == SAMPLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SETTLE;
            cnt     <= '0;
            col     <= NUM_COLS'(1);
            col_idx <= '0;
            en      <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                        cnt   <= '0;
                        en    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (cnt == SAMPLE_LAST) begin
                        // column advances on the same edge that re-enters SETTLE
                        state   <= SETTLE;
                        cnt     <= '0;
                        en      <= 1'b0;
                        col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
                        col_idx <= col_idx + 2'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SETTLE;
                    cnt   <= '0;
                    en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, suppresses repeats from held keys and
// hands one key code at a time to the request logic over valid/ready.
//   clk, rst      : clock, asynchronous active-high reset
//   col           : one-hot column drive
//   en            : enable to the per-column edge-detect stage
//   row           : synchronized raw row levels (high = pressed)
//   button_pulse  : per-row rising-edge pulses from the edge-detect stage
//   key_code      : {col_idx, row_idx} of the buffered key
//   key_valid     : key_code holds an unconsumed key
//   key_ready     : consumer accepts key_code this cycle
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SAMPLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NUM_COLS-1:0] col,
    output logic                en,
    input  logic [NUM_ROWS-1:0] row,
    input  logic [NUM_ROWS-1:0] button_pulse,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready
);

    logic [1:0]          col_idx;
    logic                slot_last;
    logic [NUM_ROWS-1:0] held [NUM_COLS];
    logic [NUM_ROWS-1:0] cand;
    logic [NUM_ROWS-1:0] held_next;
    logic [1:0]          row_sel;
    logic                accept;
    key_code_t           code_q;

    keypad_col_sequencer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SAMPLE_CYCLES (SAMPLE_CYCLES)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .col_idx   (col_idx),
        .en        (en),
        .slot_last (slot_last)
    );

    // en doubles as the SAMPLE qualifier for incoming pulses
    assign cand    = button_pulse & ~held[col_idx] & {NUM_ROWS{en}};
    assign row_sel = lowest_set(cand);
    assign accept  = (|cand) && (!key_valid || key_ready);

    // release mask first, then the newly accepted bit so it wins on a tie
    always_comb begin
        held_next = held[col_idx];
        if (slot_last) begin
            held_next = held_next & row;
        end
        if (accept) begin
            held_next[row_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_COLS; i++) begin
                held[i] <= '0;
            end
            code_q    <= '0;
            key_valid <= 1'b0;
        end else begin
            held[col_idx] <= held_next;
            if (accept) begin
                code_q    <= '{col: col_idx, row: row_sel};
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

    assign key_code = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed stimulus for keypad_scanner with a cycle-count
// based reference model compared against the DUT on every cycle.
module tb_keypad_scanner;

    localparam int SETTLE = 2;
    localparam int SAMPLE = 4;
    localparam int SLOT   = SETTLE + SAMPLE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col;
    logic       en;
    logic [3:0] row = '0;
    logic [3:0] button_pulse = '0;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    // keyboard emulation: pressed[c*4+r]
    logic [15:0] pressed = '0;
    int          pulse_phase = 3;

    // reference model state
    int          m_t;
    logic        m_valid;
    logic [3:0]  m_code;
    logic [15:0] m_held;

    logic [3:0]  xfer_q [$];

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .SAMPLE_CYCLES (SAMPLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .col          (col),
        .en           (en),
        .row          (row),
        .button_pulse (button_pulse),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_ready    (key_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // model: column and phase follow from the cycle count since reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t     <= 0;
            m_valid <= 1'b0;
            m_code  <= '0;
            m_held  <= '0;
        end else begin
            automatic int          c     = (m_t / SLOT) % 4;
            automatic int          ph    = m_t % SLOT;
            automatic bit          found = 0;
            automatic int          r     = 0;
            automatic logic        v     = m_valid;
            automatic logic [15:0] h     = m_held;
            if (ph >= SETTLE) begin
                for (int i = 0; i < 4; i++) begin
                    if (!found && button_pulse[i] && !m_held[c*4+i]) begin
                        found = 1;
                        r     = i;
                    end
                end
            end
            if (v && key_ready) v = 1'b0;
            if (ph == SLOT - 1) begin
                for (int i = 0; i < 4; i++) if (!row[i]) h[c*4+i] = 1'b0;
            end
            if (found && !v) begin
                h[c*4+r] = 1'b1;
                v        = 1'b1;
                m_code   <= 4'(c*4 + r);
            end
            m_valid <= v;
            m_held  <= h;
            m_t     <= m_t + 1;
        end
    end

    // log DUT transfers
    always @(posedge clk) begin
        if (!rst && key_valid && key_ready) xfer_q.push_back(key_code);
    end

    // keyboard / edge-detect emulation
    always @(negedge clk) begin
        automatic int         c  = (m_t / SLOT) % 4;
        automatic int         ph = m_t % SLOT;
        automatic logic [3:0] rv;
        for (int i = 0; i < 4; i++) rv[i] = pressed[c*4+i];
        row          = rv;
        button_pulse = (ph == pulse_phase) ? rv : 4'b0000;
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("col",       8'(col),       8'(4'b0001 << ((m_t / SLOT) % 4)));
            chk("en",        8'(en),        8'((m_t % SLOT) >= SETTLE));
            chk("key_valid", 8'(key_valid), 8'(m_valid));
            chk("key_code",  8'(key_code),  8'(m_code));
        end
    end

    task automatic wait_slot(input int c, input int ph);
        int n = 0;
        while (!(((m_t / SLOT) % 4) == c && (m_t % SLOT) == ph) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_slot_timeout", 8'(n >= 60), 8'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_col", 8'(col), 8'h01);
        chk("rst_en", 8'(en), 8'h00);
        chk("rst_valid", 8'(key_valid), 8'h00);
        chk("rst_code", 8'(key_code), 8'h00);
        rst = 1'b0;

        // idle scan with literal pins on slot boundaries
        wait_slot(1, 1);
        chk("idle_c1p1_col", 8'(col), 8'h02);
        chk("idle_c1p1_en", 8'(en), 8'h00);
        @(negedge clk);
        chk("idle_c1p2_en", 8'(en), 8'h01);
        wait_slot(3, 5);
        chk("idle_c3p5_col", 8'(col), 8'h08);
        chk("idle_c3p5_en", 8'(en), 8'h01);
        @(negedge clk);
        chk("idle_wrap_col", 8'(col), 8'h01);
        chk("idle_wrap_en", 8'(en), 8'h00);
        repeat (24) @(negedge clk);
        chk("idle_no_xfer", 8'(xfer_q.size()), 8'd0);

        // held key: one report over four scans
        pressed[1*4+2] = 1'b1;
        repeat (96) @(negedge clk);
        chk("held_xfer_cnt", 8'(xfer_q.size()), 8'd1);
        if (xfer_q.size() >= 1) chk("held_code", 8'(xfer_q[0]), 8'h06);

        // release then press again
        pressed = '0;
        repeat (48) @(negedge clk);
        pressed[1*4+2] = 1'b1;
        repeat (30) @(negedge clk);
        chk("repress_xfer_cnt", 8'(xfer_q.size()), 8'd2);
        if (xfer_q.size() >= 2) chk("repress_code", 8'(xfer_q[1]), 8'h06);
        pressed = '0;
        repeat (30) @(negedge clk);

        // buffer full: two simultaneous rows in col0
        key_ready = 1'b0;
        wait_slot(3, 0);
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        repeat (60) @(negedge clk);
        chk("full_valid", 8'(key_valid), 8'h01);
        chk("full_code", 8'(key_code), 8'h00);
        key_ready = 1'b1;
        repeat (30) @(negedge clk);
        chk("full_xfer_cnt", 8'(xfer_q.size()), 8'd4);
        if (xfer_q.size() >= 4) begin
            chk("full_first", 8'(xfer_q[2]), 8'h00);
            chk("full_second", 8'(xfer_q[3]), 8'h03);
        end
        pressed = '0;
        repeat (30) @(negedge clk);

        // pulses only in SETTLE are ignored
        pulse_phase = 0;
        wait_slot(1, 2);
        pressed[2*4+1] = 1'b1;
        repeat (48) @(negedge clk);
        chk("settle_no_xfer", 8'(xfer_q.size()), 8'd4);
        chk("settle_valid", 8'(key_valid), 8'h00);
        pressed = '0;
        pulse_phase = 3;

        // reset mid-SAMPLE with a pending key
        key_ready = 1'b0;
        wait_slot(2, 0);
        pressed[3*4+0] = 1'b1;
        wait_slot(3, 5);
        chk("pre_rst_valid", 8'(key_valid), 8'h01);
        chk("pre_rst_code", 8'(key_code), 8'h0c);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_col", 8'(col), 8'h01);
        chk("async_rst_en", 8'(en), 8'h00);
        chk("async_rst_valid", 8'(key_valid), 8'h00);
        pressed = '0;
        key_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("restart_col", 8'(col), 8'h01);
        chk("restart_en", 8'(en), 8'h01);
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream/downstream partner of the per-column edge-detect stage in the elevator keypad path.
- Sequences the 4x4 keypad columns one-hot and drives that stage's `en`.
- Consumes its per-row rising-edge pulses (`button_pulse`) and the raw synchronized rows.
- Suppresses repeats from held keys and hands one key code at a time to the request logic over a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 2, cycles a column is driven before `en` asserts (line settling).
- SAMPLE_CYCLES, 4, cycles `en` is held high per column slot; must be >= 3.
- NUM_COLS, 4, keypad columns; fixed at 4 for this revision.
- NUM_ROWS, 4, keypad rows; fixed at 4 for this revision.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- col  out  4  one-hot column drive, active-high
- en  out  1  enable to the edge-detect stage; high only during the SAMPLE phase
- row  in  4  synchronized raw row levels, high = pressed; the same signal that feeds the edge-detect stage
- button_pulse  in  4  per-row rising-edge pulses from the edge-detect stage
- key_code  out  4  {col_idx[1:0], row_idx[1:0]}
- key_valid  out  1  key_code holds an unconsumed key
- key_ready  in  1  consumer accepts key_code this cycle

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous and active-high.
- Reset values:
  - col = 4'b0001, col_idx = 0, en = 0
  - state = SETTLE, counter = 0
  - held map (16 bits) = 0
  - key_valid = 0, key_code = 0
- FSM states:
  - SETTLE: stay SETTLE_CYCLES cycles, en = 0, then go to SAMPLE.
  - SAMPLE: stay SAMPLE_CYCLES cycles, en = 1.
  - On the last SAMPLE cycle: col_idx increments mod 4, col rotates left (wraps 4'b1000 -> 4'b0001), state returns to SETTLE.
  - Slot length is SETTLE_CYCLES + SAMPLE_CYCLES (6 by default); a full scan is 24 cycles.
- Registered outputs: col and en are registered; col changes on the same edge that enters SETTLE.
- Edge-detect latency: the edge-detect stage produces a held key's pulse 1 cycle after en rises, and re-produces it on every re-entry to that column. Repeat suppression is therefore mandatory here.
- Pulse qualification: button_pulse is honoured only in SAMPLE and is ignored in SETTLE.
- Candidate selection:
  - Candidate = lowest-index set bit of (button_pulse & ~held[col_idx]).
  - Other simultaneous bits are not marked held; they are reported on a later scan pass.
- Accept:
  - Condition: a candidate exists and the buffer is free, i.e. key_valid = 0 or (key_valid & key_ready) this cycle.
  - Next cycle: key_code = {col_idx, row_idx}, key_valid = 1.
  - The held bit for that key is set.
- Buffer full (key_valid = 1 and key_ready = 0): candidate is not accepted and its held bit stays clear, so it is retried on the next pass. Nothing is lost while the key remains pressed.
- Handshake:
  - key_valid and key_code stay stable until key_valid & key_ready.
  - Transfer and a new accept in the same cycle leave key_valid at 1 with the new code.
  - Transfer with no new candidate drops key_valid to 0.
- Release: on the last SAMPLE cycle, held[col_idx] <= held[col_idx] & row. A released key clears its bit, so the next press is reported again.
- Simultaneous pulse and release update on the same edge: the newly accepted bit takes priority over the release mask.
- Reset mid-slot: asynchronous return to all reset values; a pending key_valid is dropped.

Decomposition:
- Package keypad_pkg holds:
  - NUM_COLS and NUM_ROWS
  - typedef key_code_t (4-bit struct {col, row})
  - enum scan_state_t {SETTLE, SAMPLE}
  - function for the lowest-set-bit index
- One sub-module, keypad_col_sequencer: phase counter, FSM, col/en/col_idx generation, and a `slot_last` strobe.
- The top level holds the held map, candidate select and output buffer.

Test Plan:
- Reset, idle 48 cycles -> col sequence 0001, 0010, 0100, 1000, 0001, … with 6-cycle slots; en high only in cycles 2–5 of each slot; key_valid stays 0.
- Press col1/row2 (row = 4'b0100 during col1 slots), drive a 1-cycle button_pulse in SAMPLE, key_ready = 1 -> one key_valid pulse with key_code = 4'b0110; held for 3 more scans, pulse repeated each pass -> no further key_valid.
- Release the key, press again after 2 scans -> a second key_code = 6 is reported.
- key_ready = 0, pulse col0 rows 0 and 3 together (4'b1001) -> key_code = 0 held stable; after key_ready = 1, the next col0 pass reports key_code = 4'b0011.
- Pulse applied during SETTLE only -> ignored, no key_valid.
- Assert rst mid-SAMPLE with key_valid = 1 -> immediately col = 0001, en = 0, key_valid = 0; after release the scan restarts from col0.
